// File: rtl/vector_pkg.sv
// vector_pkg: shared pixel field positions, scanout FSM states and the 16-entry
// RGB palette used by vector_scanout and vector_palette.
package vector_pkg;

  localparam int COL_MSB = 7;
  localparam int COL_LSB = 4;
  localparam int INT_MSB = 3;
  localparam int INT_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_MODIFY = 2'd2,
    ST_WRITE  = 2'd3
  } state_t;

  // 24-bit {r,g,b} per colour index.
  localparam logic [23:0] PAL [0:15] = '{
    24'hFFFFFF, 24'hFF0000, 24'h00FF00, 24'h0000FF,
    24'hFFFF00, 24'h00FFFF, 24'hFF00FF, 24'hFF8000,
    24'h808080, 24'h80FF80, 24'h8080FF, 24'hFF8080,
    24'h40C0FF, 24'hC040FF, 24'hFFC040, 24'h202020
  };

endpackage

// File: rtl/vector_scanout_if.sv
// vector_scanout_if: framebuffer scan port plus the renderer's write snoop.
// Handshake: fb_q is valid one clk after fb_addr; fb_wr is a single-clk strobe with fb_addr/fb_wdata stable.
interface vector_scanout_if;
  logic [15:0] fb_addr;
  logic [7:0]  fb_q;
  logic        fb_wr;
  logic [7:0]  fb_wdata;
  logic        draw_wr;
  logic [15:0] draw_addr;

  modport master (
    output fb_addr, fb_wr, fb_wdata,
    input  fb_q, draw_wr, draw_addr
  );

  modport slave (
    input  fb_addr, fb_wr, fb_wdata,
    output fb_q, draw_wr, draw_addr
  );
endinterface

// File: rtl/vector_palette.sv
// vector_palette: combinational (colour index, intensity) -> RGBA scaling.
// Each channel is PAL[idx].ch * int, keeping the top 8 of the 12-bit product.
module vector_palette
  import vector_pkg::*;
(
  input  logic [3:0] idx,
  input  logic [3:0] intensity,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b,
  output logic       a
);
  logic [23:0] rgb;
  logic [11:0] prod_r, prod_g, prod_b;

  always_comb begin
    rgb    = PAL[idx];
    prod_r = {4'b0, rgb[23:16]} * {8'b0, intensity};
    prod_g = {4'b0, rgb[15:8]}  * {8'b0, intensity};
    prod_b = {4'b0, rgb[7:0]}   * {8'b0, intensity};
    r      = prod_r[11:4];
    g      = prod_g[11:4];
    b      = prod_b[11:4];
    a      = (intensity != 4'd0);
  end
endmodule

// File: rtl/vector_scanout.sv
// vector_scanout: read-modify-write scanout of the vector framebuffer with phosphor fade.
// Define VECTOR_GLOW_EN to add per-line horizontal glow on the emitted intensity.
module vector_scanout
  import vector_pkg::*;
#(
  parameter int DECAY_STEP  = 1,
  parameter int FADE_FRAMES = 2,
  parameter int GLOW_DROP   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce_pix,
  input  logic             pause,
  input  logic [8:0]       hcnt,
  input  logic [8:0]       vcnt,
  input  logic             vblank,
  vector_scanout_if.master fb,
  output logic [7:0]       vector_r,
  output logic [7:0]       vector_g,
  output logic [7:0]       vector_b,
  output logic             vector_a,
  output state_t           state_dbg
);
  localparam logic [3:0] STEP      = 4'(DECAY_STEP);
  localparam logic [7:0] FADE_LAST = 8'(FADE_FRAMES - 1);

  state_t      state, state_n;
  logic        ce_q, vblank_q;
  logic [7:0]  frame_cnt;
  logic [15:0] addr_q;
  logic [7:0]  pix_q, wdata_q;
  logic        wr_ok_q, cancel_q, line_start_q;

  logic        ce_rise, vblank_rise, in_win, draw_hit;
  logic [3:0]  src_int, new_int;
  logic [7:0]  new_byte;
  logic [3:0]  emit_idx, emit_int;
  logic [7:0]  pal_r, pal_g, pal_b;
  logic        pal_a;

  assign ce_rise     = ce_pix & ~ce_q;
  assign vblank_rise = vblank & ~vblank_q;
  assign in_win      = ~hcnt[8] & ~vcnt[8];
  assign draw_hit    = fb.draw_wr && (fb.draw_addr == addr_q);
  assign src_int     = fb.fb_q[INT_MSB:INT_LSB];
  assign new_int     = (src_int > STEP) ? (src_int - STEP) : 4'd0;
  // A fully faded pixel also loses its colour so the byte reads as empty.
  assign new_byte    = (new_int == 4'd0) ? 8'h00 : {fb.fb_q[COL_MSB:COL_LSB], new_int};

  assign fb.fb_addr  = addr_q;
  assign fb.fb_wdata = wdata_q;
  assign state_dbg   = state;

  always_comb begin
    state_n  = state;
    fb.fb_wr = 1'b0;
    unique case (state)
      ST_IDLE:   if (ce_rise && in_win) state_n = ST_READ;
      ST_READ:   state_n = ST_MODIFY;
      ST_MODIFY: state_n = ST_WRITE;
      ST_WRITE: begin
        state_n  = ST_IDLE;
        // Renderer traffic in this very clk still wins over the fade write.
        fb.fb_wr = wr_ok_q && !cancel_q && !draw_hit && !pause;
      end
      default:   state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      ce_q         <= 1'b0;
      vblank_q     <= 1'b0;
      frame_cnt    <= 8'd0;
      addr_q       <= 16'd0;
      pix_q        <= 8'd0;
      wdata_q      <= 8'd0;
      wr_ok_q      <= 1'b0;
      cancel_q     <= 1'b0;
      line_start_q <= 1'b0;
      vector_r     <= 8'd0;
      vector_g     <= 8'd0;
      vector_b     <= 8'd0;
      vector_a     <= 1'b0;
    end else begin
      state    <= state_n;
      ce_q     <= ce_pix;
      vblank_q <= vblank;
      if (vblank_rise) frame_cnt <= (frame_cnt >= FADE_LAST) ? 8'd0 : frame_cnt + 8'd1;
      unique case (state)
        ST_IDLE: begin
          if (ce_rise) begin
            if (in_win) begin
              addr_q       <= {vcnt[7:0], hcnt[7:0]};
              cancel_q     <= 1'b0;
              line_start_q <= (hcnt == 9'd0);
            end else begin
              vector_r <= 8'd0;
              vector_g <= 8'd0;
              vector_b <= 8'd0;
              vector_a <= 1'b0;
            end
          end
        end
        ST_READ: begin
          if (draw_hit) cancel_q <= 1'b1;
        end
        ST_MODIFY: begin
          pix_q   <= fb.fb_q;
          wdata_q <= new_byte;
          wr_ok_q <= (frame_cnt == 8'd0) && !pause && (src_int != 4'd0);
          if (draw_hit) cancel_q <= 1'b1;
        end
        ST_WRITE: begin
          vector_r <= pal_r;
          vector_g <= pal_g;
          vector_b <= pal_b;
          vector_a <= pal_a;
        end
        default: ;
      endcase
    end
  end

`ifdef VECTOR_GLOW_EN
  localparam logic [3:0] DROP = 4'(GLOW_DROP);

  logic [3:0] glow_int, glow_idx, glow_base, glow_fall;

  always_comb begin
    glow_base = line_start_q ? 4'd0 : glow_int;
    glow_fall = (glow_base > DROP) ? (glow_base - DROP) : 4'd0;
    emit_int  = (pix_q[INT_MSB:INT_LSB] > glow_fall) ? pix_q[INT_MSB:INT_LSB] : glow_fall;
    emit_idx  = (pix_q[INT_MSB:INT_LSB] != 4'd0) ? pix_q[COL_MSB:COL_LSB] : glow_idx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      glow_int <= 4'd0;
      glow_idx <= 4'd0;
    end else if (state == ST_IDLE && ce_rise && !in_win) begin
      glow_int <= 4'd0;
    end else if (state == ST_WRITE) begin
      glow_int <= emit_int;
      glow_idx <= emit_idx;
    end
  end
`else
  assign emit_int = pix_q[INT_MSB:INT_LSB];
  assign emit_idx = pix_q[COL_MSB:COL_LSB];
`endif

  vector_palette u_palette (
    .idx       (emit_idx),
    .intensity (emit_int),
    .r         (pal_r),
    .g         (pal_g),
    .b         (pal_b),
    .a         (pal_a)
  );

endmodule
